hamming_decoder: RTL

SECDED decoder for the (8,4) extended Hamming codeword produced by the team's 4-bit encoder. Accepts one codeword per cycle over a valid/ready handshake and computes the syndrome and overall parity. Corrects any single-bit error, flags double-bit errors, and returns the 4 data bits after a 2-stage pipeline. Saturating error counters support link-quality reporting on the TinyTapeout top-level.

---
 rtl/hamming_pkg.sv | 28 ++
 rtl/hamming_syndrome.sv | 26 ++
 rtl/hamming_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared definitions for the (8,4) extended Hamming SECDED codec.
//   Codeword layout, bit7..bit0: {p_all, d3, d2, d1, p4, d0, p2, p1}.
//   Contents:
//     CODE_W / DATA_W  codeword and data widths
//     P1..PALL         codeword bit index of each field
//     err_kind_t       classification of a received codeword
package hamming_pkg;

  localparam int CODE_W = 8;
  localparam int DATA_W = 4;

  localparam int P1   = 0;
  localparam int P2   = 1;
  localparam int D0   = 2;
  localparam int P4   = 3;
  localparam int D1   = 4;
  localparam int D2   = 5;
  localparam int D3   = 6;
  localparam int PALL = 7;

  typedef enum logic [1:0] {
    CLEAN,
    SINGLE,
    DOUBLE
  } err_kind_t;

endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome
//   Purely combinational syndrome and overall-parity generator for an
//   (8,4) extended Hamming codeword. Shared with the encoder self-check.
//   Ports:
//     cw   in   8  codeword {p_all,d3,d2,d1,p4,d0,p2,p1}
//     syn  out  3  Hamming syndrome; nonzero value n points at cw[n-1]
//     par  out  1  XOR of all eight bits; 0 for even parity
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] cw,
  output logic [2:0]        syn,
  output logic              par
);

  // Each syndrome bit re-checks one parity group, so the syndrome value
  // equals the 1-based Hamming position of a single flipped bit.
  always_comb begin
    syn[0] = cw[P1] ^ cw[D0] ^ cw[D1] ^ cw[D3];
    syn[1] = cw[P2] ^ cw[D0] ^ cw[D2] ^ cw[D3];
    syn[2] = cw[P4] ^ cw[D1] ^ cw[D2] ^ cw[D3];
  end

  assign par = ^cw;

endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder
//   Two-stage pipelined SECDED decoder for (8,4) extended Hamming codewords
//   with valid/ready handshakes on both sides and saturating error counters.
//   Ports:
//     clk, rst             clock; synchronous active-high reset
//     in_valid/in_ready    input handshake; code_in is the codeword
//     out_valid/out_ready  output handshake
//     data_out             corrected data {d3,d2,d1,d0}
//     single_err           one bit was corrected (p_all included)
//     double_err           uncorrectable error; data_out is the raw data
//     err_pos              index of the corrected bit, else 0
//     clr_cnt              synchronous clear of both counters
//     corr_cnt/uncorr_cnt  transferred single/double error counts
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              single_err,
  output logic              double_err,
  output logic [2:0]        err_pos,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic              s2_adv;
  logic [2:0]        syn;
  logic              par;
  err_kind_t         kind;
  logic              fix;
  logic [2:0]        pos_c;
  logic [DATA_W-1:0] data_c;
  logic              xfer;

  // out_valid doubles as the stage-2 valid bit. in_ready depends
  // combinationally on out_ready because there is no skid buffer.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign xfer     = out_valid && out_ready;

  hamming_syndrome u_syndrome (
    .cw  (s1_code),
    .syn (syn),
    .par (par)
  );

  // Odd parity means an odd number of flips, taken to be one. A zero
  // syndrome with odd parity isolates the flip to p_all itself, which
  // leaves the data untouched. Even parity with a nonzero syndrome is a
  // double error and the data is passed through uncorrected.
  always_comb begin
    kind  = CLEAN;
    fix   = 1'b0;
    pos_c = 3'd0;
    if (par) begin
      kind = SINGLE;
      if (syn == 3'd0) begin
        pos_c = 3'(PALL);
      end else begin
        fix   = 1'b1;
        pos_c = syn - 3'd1;
      end
    end else if (syn != 3'd0) begin
      kind = DOUBLE;
    end
    data_c = {s1_code[D3] ^ (fix && (syn == 3'(D3 + 1))),
              s1_code[D2] ^ (fix && (syn == 3'(D2 + 1))),
              s1_code[D1] ^ (fix && (syn == 3'(D1 + 1))),
              s1_code[D0] ^ (fix && (syn == 3'(D0 + 1)))};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= code_in;
      end
    end
  end

  // Result registers only load when a real word moves in, so they stay
  // frozen while a result waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      single_err <= 1'b0;
      double_err <= 1'b0;
      err_pos    <= 3'd0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= data_c;
        single_err <= (kind == SINGLE);
        double_err <= (kind == DOUBLE);
        err_pos    <= pos_c;
      end
    end
  end

  // Counters only see transferred results; clear beats a same-cycle
  // increment and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (single_err && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (double_err && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

endmodule
